digitalclock_mode_ctrl: RTL and testbench

DIGITALCLOCK_MODE_CTRL -- requirements
Module: digitalclock_mode_ctrl

---
 rtl/digitalclock_mode_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_digitalclock_mode_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digitalclock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// digitalclock_mode_ctrl
//
// Mode controller for a digital clock. Two raw push-buttons (mode, back) are
// debounced independently. A rising edge of a debounced level is a "press".
// Mode presses step through NUM_MODES modes (mode 0 = normal time display,
// all others are setting modes), back presses return to the display mode, and
// an idle timer drops a forgotten setting mode back to the display.
//
// Ports
//   clk           in   system clock, all state changes on the rising edge
//   rst           in   synchronous, active-high reset
//   mode          in   raw mode button, active-high, already synchronous
//   back          in   raw return-to-display button, active-high, synchronous
//   mode_idx      out  current mode (registered), MW bits
//   in_set        out  high whenever mode_idx != 0 (decoded from mode_idx)
//   mode_changed  out  one-cycle pulse in the first cycle mode_idx shows a
//                      new value (registered)
//   timeout_evt   out  one-cycle pulse in the first cycle after an idle
//                      timeout forced mode 0 (registered)
//
// Also contains digitalclock_debounce, the per-button debouncer.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// digitalclock_debounce
//
// Accepts a change of the raw level only after DEBOUNCE_CYCLES consecutive
// samples that differ from the current debounced level. A mismatch run that
// ends early restarts the count, so a glitch shorter than DEBOUNCE_CYCLES
// samples never reaches the debounced level.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   raw_i    in   raw button level
//   press_o  out  high for one cycle when the debounced level rises
// -----------------------------------------------------------------------------
module digitalclock_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic press_o
);

   // A 1-cycle debouncer still needs a 1-bit counter to stay legal.
   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          db_q, db_d;
   logic          db_prev_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (raw_i != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d  = raw_i;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         db_q      <= db_d;
         db_prev_q <= db_q;
         cnt_q     <= cnt_d;
      end
   end

   // The press is visible in the cycle after the debounced level rose; the
   // mode FSM consumes it on the following edge.
   assign press_o = db_q & ~db_prev_q;

endmodule : digitalclock_debounce


module digitalclock_mode_ctrl #(
   parameter int unsigned NUM_MODES       = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 16,
   localparam int unsigned MW = ($clog2(NUM_MODES) > 1) ? $clog2(NUM_MODES) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mode,
   input  logic          back,
   output logic [MW-1:0] mode_idx,
   output logic          in_set,
   output logic          mode_changed,
   output logic          timeout_evt
);

   localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES) > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [MW-1:0] MODE_LAST = MW'(NUM_MODES - 1);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

   // ---------------------------------------------------------------------
   // Button conditioning
   // ---------------------------------------------------------------------
   logic mode_press;
   logic back_press;

   digitalclock_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_mode (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (mode),
      .press_o (mode_press)
   );

   digitalclock_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_back (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (back),
      .press_o (back_press)
   );

   // ---------------------------------------------------------------------
   // Mode / idle-timer next state
   // ---------------------------------------------------------------------
   logic [MW-1:0] mode_idx_q, mode_idx_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          mode_changed_q, mode_changed_d;
   logic          timeout_evt_q, timeout_evt_d;

   always_comb begin
      mode_idx_d    = mode_idx_q;
      tcnt_d        = tcnt_q;
      timeout_evt_d = 1'b0;

      // Priority: back press, then mode press, then timeout. Any press
      // restarts the idle timer, so a press on the expiry cycle beats it.
      if (back_press) begin
         mode_idx_d = '0;
         tcnt_d     = '0;
      end else if (mode_press) begin
         mode_idx_d = (mode_idx_q == MODE_LAST) ? '0 : mode_idx_q + MW'(1);
         tcnt_d     = '0;
      end else if (mode_idx_q == '0) begin
         tcnt_d = '0;
      end else if (tcnt_q == TCNT_LAST) begin
         mode_idx_d    = '0;
         tcnt_d        = '0;
         timeout_evt_d = 1'b1;
      end else begin
         tcnt_d = tcnt_q + TW'(1);
      end

      // Only a real value change is reported (back in mode 0 is silent).
      mode_changed_d = (mode_idx_d != mode_idx_q);
   end

   // NOTE: synchronous reset lives inside the clocked block; it is sampled
   // only on the rising edge, like any other data input.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_idx_q     <= '0;
         tcnt_q         <= '0;
         mode_changed_q <= 1'b0;
         timeout_evt_q  <= 1'b0;
      end else begin
         mode_idx_q     <= mode_idx_d;
         tcnt_q         <= tcnt_d;
         mode_changed_q <= mode_changed_d;
         timeout_evt_q  <= timeout_evt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign mode_idx     = mode_idx_q;
   assign in_set       = (mode_idx_q != '0);
   assign mode_changed = mode_changed_q;
   assign timeout_evt  = timeout_evt_q;

endmodule : digitalclock_mode_ctrl

// File: tb/tb_digitalclock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digitalclock_mode_ctrl
//
// Self-checking bench. A behavioural model (run lengths of equal raw samples,
// press edges, and an edge-number based idle timer) predicts every output on
// every cycle; a single compare process checks the DUT against it. Directed
// scenarios add hand-computed literal expectations, followed by randomized
// button traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_digitalclock_mode_ctrl;

   localparam int NUM_MODES       = 3;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int TIMEOUT_CYCLES  = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode;
   logic       back;
   logic [1:0] mode_idx;
   logic       in_set;
   logic       mode_changed;
   logic       timeout_evt;

   int errors = 0;
   int checks = 0;

   digitalclock_mode_ctrl #(
      .NUM_MODES       (NUM_MODES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mode         (mode),
      .back         (back),
      .mode_idx     (mode_idx),
      .in_set       (in_set),
      .mode_changed (mode_changed),
      .timeout_evt  (timeout_evt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model, advanced on every rising edge
   // ---------------------------------------------------------------------
   int edge_n = 0;
   bit model_valid = 0;
   // per button: length of the current run of equal raw samples, last raw,
   // debounced level and its value one cycle earlier
   int run_m, run_b;
   bit last_m, last_b, db_m, db_b, prev_m, prev_b;
   int m_mode, last_act;
   bit m_changed, m_tevt;

   always @(posedge clk) begin
      bit press_m, press_b;
      int old;
      edge_n++;
      model_valid = 1;
      if (rst) begin
         run_m = 0; run_b = 0; db_m = 0; db_b = 0; prev_m = 0; prev_b = 0;
         m_mode = 0; m_changed = 0; m_tevt = 0; last_act = edge_n;
      end else begin
         press_m = db_m && !prev_m;
         press_b = db_b && !prev_b;
         old     = m_mode;
         m_tevt  = 0;
         if (press_b)      m_mode = 0;
         else if (press_m) m_mode = (m_mode + 1) % NUM_MODES;
         else if (m_mode != 0 && edge_n - last_act == TIMEOUT_CYCLES) begin
            m_mode = 0;
            m_tevt = 1;
         end
         if (press_m || press_b) last_act = edge_n;
         m_changed = (m_mode != old);

         prev_m = db_m;
         prev_b = db_b;
         if (run_m > 0 && mode == last_m) run_m++; else run_m = 1;
         last_m = mode;
         if (mode != db_m && run_m >= DEBOUNCE_CYCLES) db_m = mode;
         if (run_b > 0 && back == last_b) run_b++; else run_b = 1;
         last_b = back;
         if (back != db_b && run_b >= DEBOUNCE_CYCLES) db_b = back;
      end
   end

   // Single compare process, away from the active edge.
   always @(negedge clk) begin
      if (model_valid) begin
         check("mode_idx",     int'(mode_idx),     m_mode);
         check("in_set",       int'(in_set),       int'(m_mode != 0));
         check("mode_changed", int'(mode_changed), int'(m_changed));
         check("timeout_evt",  int'(timeout_evt),  int'(m_tevt));
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   // Apply inputs just after a falling edge and wait one full cycle.
   task automatic drive(input bit r, input bit m, input bit b);
      rst  = r;
      mode = m;
      back = b;
      @(negedge clk);
   endtask

   task automatic hold(input bit m, input bit b, input int n);
      for (int i = 0; i < n; i++) drive(0, m, b);
   endtask

   // Clean mode press: mode_idx changes on the 5th high sample.
   task automatic press_mode();
      hold(1, 0, DEBOUNCE_CYCLES + 1);
      hold(0, 0, DEBOUNCE_CYCLES);
   endtask

   initial begin
      int seg_m, seg_b;
      bit mv, bv, rv;
      rst = 1; mode = 0; back = 0;
      repeat (2) @(negedge clk);

      // reset state
      check("rst_mode_idx", int'(mode_idx), 0);
      check("rst_in_set", int'(in_set), 0);
      check("rst_mode_changed", int'(mode_changed), 0);
      check("rst_timeout_evt", int'(timeout_evt), 0);

      // debounce latency: no change after 4 samples, change after the 5th edge
      hold(1, 0, 4);
      check("lat_before", int'(mode_idx), 0);
      hold(1, 0, 1);
      check("lat_mode", int'(mode_idx), 1);
      check("lat_pulse", int'(mode_changed), 1);
      hold(1, 0, 1);
      check("lat_pulse_end", int'(mode_changed), 0);
      hold(1, 0, 10);
      check("held_no_repeat", int'(mode_idx), 1);
      hold(0, 0, DEBOUNCE_CYCLES);

      // glitch of 3 samples is ignored
      drive(1, 0, 0);
      hold(1, 0, 3);
      hold(0, 0, 8);
      check("glitch_mode", int'(mode_idx), 0);

      // wrap 1,2,0
      press_mode(); check("wrap_1", int'(mode_idx), 1);
      press_mode(); check("wrap_2", int'(mode_idx), 2);
      press_mode(); check("wrap_0", int'(mode_idx), 0);

      // timeout exactly 16 edges after entering mode 1
      drive(1, 0, 0);
      hold(1, 0, 5);
      check("to_enter", int'(mode_idx), 1);
      hold(0, 0, 15);
      check("to_not_yet", int'(mode_idx), 1);
      hold(0, 0, 1);
      check("to_mode", int'(mode_idx), 0);
      check("to_evt", int'(timeout_evt), 1);
      check("to_changed", int'(mode_changed), 1);
      hold(0, 0, 1);
      check("to_evt_end", int'(timeout_evt), 0);

      // simultaneous mode and back in mode 2: back wins
      drive(1, 0, 0);
      press_mode(); press_mode();
      check("col_mode2", int'(mode_idx), 2);
      hold(1, 1, 5);
      check("col_mode", int'(mode_idx), 0);
      check("col_evt", int'(timeout_evt), 0);
      hold(0, 0, DEBOUNCE_CYCLES);

      // back press in mode 0 is silent
      hold(0, 1, 5);
      check("back0_mode", int'(mode_idx), 0);
      check("back0_changed", int'(mode_changed), 0);
      hold(0, 0, DEBOUNCE_CYCLES);

      // press landing on the expiry cycle advances the mode instead
      drive(1, 0, 0);
      hold(1, 0, 5);                // entry edge E
      hold(0, 0, 11);               // E+1..E+11
      hold(1, 0, 4);                // E+12..E+15, db rises at E+15
      check("exp_before", int'(mode_idx), 1);
      hold(1, 0, 1);                // E+16: press vs expiry
      check("exp_mode", int'(mode_idx), 2);
      check("exp_evt", int'(timeout_evt), 0);
      hold(0, 0, DEBOUNCE_CYCLES);

      // reset in mode 2 with a debounce in progress, button held through it
      drive(1, 0, 0);
      press_mode(); press_mode();
      hold(1, 0, 2);
      drive(1, 1, 0);
      check("mrst_mode", int'(mode_idx), 0);
      check("mrst_changed", int'(mode_changed), 0);
      check("mrst_evt", int'(timeout_evt), 0);
      hold(1, 0, 4);
      check("mrst_held4", int'(mode_idx), 0);
      hold(1, 0, 1);
      check("mrst_held5", int'(mode_idx), 1);
      hold(0, 0, DEBOUNCE_CYCLES);

      // randomized traffic
      seg_m = 0; seg_b = 0; mv = 0; bv = 0;
      for (int i = 0; i < 4000; i++) begin
         if (seg_m == 0) begin
            mv    = ($urandom_range(0, 2) == 0);
            seg_m = mv ? $urandom_range(1, 8) : $urandom_range(1, 24);
         end
         if (seg_b == 0) begin
            bv    = ($urandom_range(0, 4) == 0);
            seg_b = bv ? $urandom_range(1, 8) : $urandom_range(1, 40);
         end
         rv = ($urandom_range(0, 299) == 0);
         drive(rv, mv, bv);
         seg_m--;
         seg_b--;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule : tb_digitalclock_mode_ctrl
